// File: rtl/pc_fetch_unit_pkg.sv
// Shared fetch-stage types and constants for the Kabeta core.
package kabeta_pkg;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    HOLD
  } fetchState_t;

  localparam logic [31:0] RESET_VEC_DEF  = 32'h8000_0000;
  localparam logic [31:0] ILLOP_VEC_DEF  = 32'h8000_0004;
  localparam logic [31:0] IRQ_VEC_DEF    = 32'h8000_0008;
  localparam int unsigned SUPERVISOR_BIT = 31;
  localparam int unsigned INSTR_BYTES    = 4;

  function automatic logic [31:0] alignWord(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/ready bus between the fetch unit and imem.
interface pc_fetch_unit_if;
  logic        IMemReq;
  logic [30:0] IMemAddr;
  logic        IMemReady;
  logic [31:0] IMemData;

  modport master (output IMemReq, output IMemAddr, input IMemReady, input IMemData);
  modport slave  (input IMemReq, input IMemAddr, output IMemReady, output IMemData);
endinterface

// File: rtl/pc_fetch_unit_next_pc_select.sv
// Next-PC priority mux: Irq (user mode only) > IllOp > branch > sequential.
module next_pc_select
  import kabeta_pkg::*;
#(
  parameter logic [31:0] ILLOP_VEC = ILLOP_VEC_DEF,
  parameter logic [31:0] IRQ_VEC   = IRQ_VEC_DEF
) (
  input  logic [31:0] pc,
  input  logic [30:0] adderSum,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  input  logic        illOp,
  input  logic        irq,
  output logic        redirect,
  output logic [31:0] redirectTarget,
  output logic [31:0] seqPc
);

  logic [31:0] rawTarget;

  always_comb begin
    redirect  = 1'b0;
    rawTarget = pc;
    if (irq && !pc[SUPERVISOR_BIT]) begin
      redirect  = 1'b1;
      rawTarget = {1'b1, IRQ_VEC[30:0]};
    end else if (illOp) begin
      redirect  = 1'b1;
      rawTarget = {1'b1, ILLOP_VEC[30:0]};
    end else if (branchTaken) begin
      // A branch may drop supervisor privilege but never gain it.
      redirect  = 1'b1;
      rawTarget = {pc[SUPERVISOR_BIT] & branchTarget[SUPERVISOR_BIT], branchTarget[30:0]};
    end
    redirectTarget = alignWord(rawTarget);
    seqPc          = alignWord({pc[SUPERVISOR_BIT], adderSum});
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding instruction fetch stage of the Kabeta core.
module pc_fetch_unit
  import kabeta_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [31:0] ILLOP_VEC = ILLOP_VEC_DEF,
  parameter logic [31:0] IRQ_VEC   = IRQ_VEC_DEF
) (
  input  logic                   Clock,
  input  logic                   Reset,
  output logic [30:0]            AdderIn,
  output logic [30:0]            AdderAddend,
  input  logic [30:0]            AdderSum,
  pc_fetch_unit_if.master        IMem,
  input  logic                   Stall,
  input  logic                   BranchTaken,
  input  logic [31:0]            BranchTarget,
  input  logic                   IllOp,
  input  logic                   Irq,
  output logic                   InstrValid,
  output logic [31:0]            Instr,
  output logic [31:0]            InstrPC,
  output logic [31:0]            InstrPCPlus4
);

  fetchState_t state, stateNext;
  logic [31:0] pc, pcNext;
  logic [31:0] pendTarget, pendTargetNext;
  logic        pendFlag, pendFlagNext;
  logic        validNext;
  logic        capture;
  logic        redirect;
  logic [31:0] redirectTarget;
  logic [31:0] seqPc;

  next_pc_select #(
    .ILLOP_VEC (ILLOP_VEC),
    .IRQ_VEC   (IRQ_VEC)
  ) u_nextPc (
    .pc             (pc),
    .adderSum       (AdderSum),
    .branchTaken    (BranchTaken),
    .branchTarget   (BranchTarget),
    .illOp          (IllOp),
    .irq            (Irq),
    .redirect       (redirect),
    .redirectTarget (redirectTarget),
    .seqPc          (seqPc)
  );

  assign AdderIn       = pc[30:0];
  assign AdderAddend   = 31'(INSTR_BYTES);
  assign IMem.IMemReq  = (state == FETCH);
  assign IMem.IMemAddr = pc[30:0];

  always_comb begin
    stateNext      = state;
    pcNext         = pc;
    pendFlagNext   = pendFlag;
    pendTargetNext = pendTarget;
    capture        = 1'b0;
    // Presented word stays valid until decode takes it.
    validNext      = InstrValid & Stall;
    unique case (state)
      BOOT: stateNext = FETCH;
      FETCH: begin
        if (IMem.IMemReady) begin
          if (redirect) begin
            pcNext       = redirectTarget;
            pendFlagNext = 1'b0;
            validNext    = 1'b0;
          end else if (pendFlag) begin
            pcNext       = pendTarget;
            pendFlagNext = 1'b0;
          end else begin
            capture   = 1'b1;
            pcNext    = seqPc;
            validNext = 1'b1;
            if (Stall) stateNext = HOLD;
          end
        end else if (redirect) begin
          // Request in flight: keep the address stable, apply the redirect on Ready.
          pendFlagNext   = 1'b1;
          pendTargetNext = redirectTarget;
        end
      end
      HOLD: begin
        if (redirect) begin
          pcNext    = redirectTarget;
          validNext = 1'b0;
          stateNext = FETCH;
        end else if (!Stall) begin
          stateNext = FETCH;
        end
      end
      default: stateNext = BOOT;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state        <= BOOT;
      pc           <= RESET_VEC;
      pendFlag     <= 1'b0;
      pendTarget   <= '0;
      InstrValid   <= 1'b0;
      Instr        <= '0;
      InstrPC      <= '0;
      InstrPCPlus4 <= '0;
    end else begin
      state      <= stateNext;
      pc         <= pcNext;
      pendFlag   <= pendFlagNext;
      pendTarget <= pendTargetNext;
      InstrValid <= validNext;
      if (capture) begin
        Instr        <= IMem.IMemData;
        InstrPC      <= pc;
        InstrPCPlus4 <= {pc[SUPERVISOR_BIT], AdderSum};
      end
    end
  end

endmodule
